// File: rtl/dmem_responder.sv
// Purpose : data-memory responder for MEM-stage loads/stores over a word-organised synchronous RAM.
// Latency : WAIT_CYCLES+3 cycles from request to the DONE cycle (IDLE, WAIT x N, ACCESS, DONE).
// Backpress: mem_stall holds the pipeline from the request cycle through ACCESS; it drops in DONE.
//
// Ports:
//   clk, rst      - clock; asynchronous active-high reset
//   ReadMem       - load request        WriteMem  - store request
//   addr          - byte address (addr[1:0] unused), word index is addr[ADDR_WIDTH+1:2]
//   byte_slct     - per-byte lane enables for stores
//   wdata         - lane-aligned store data
//   raw_mem_data  - full word of the last completed load (0 after a read-type error)
//   mem_stall     - pipeline hold request (combinational)
//   mem_done      - one-cycle completion pulse
//   addr_err      - one-cycle error pulse, coincident with mem_done
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,   // word-address width, must be <= 29
    parameter int WAIT_CYCLES = 2     // wait states before each access, 0..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReadMem,
    input  logic        WriteMem,
    input  logic [31:0] addr,
    input  logic [3:0]  byte_slct,
    input  logic [31:0] wdata,
    output logic [31:0] raw_mem_data,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);
    localparam int         LP_DEPTH = 2 ** ADDR_WIDTH;

    // Word-organised array; deliberately not reset.
    logic [31:0]           r_mem [LP_DEPTH];

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [3:0]            r_bs;
    logic [31:0]           r_wdata;
    logic                  r_rd;
    logic                  r_wr;
    logic                  r_err;
    logic [31:0]           r_raw;
    logic                  r_done;
    logic                  r_aerr;

    logic                  w_req;
    logic                  w_err;
    logic                  w_mem_we;
    logic                  w_unused_addr_lsb;

    assign w_req = ReadMem | WriteMem;

    // Conflicting op, or any address bit above the array's reach.
    assign w_err = (ReadMem & WriteMem) | (|addr[31:ADDR_WIDTH+2]);

    // Byte offset within a word is meaningless for a word-organised array.
    assign w_unused_addr_lsb = ^addr[1:0];

    // Store commits at the closing edge of ACCESS; erroneous requests never touch the array.
    assign w_mem_we = (r_state == ST_ACCESS) && r_wr && !r_err;

    // The !rst term makes a reset that coincides with the ACCESS edge abandon the store.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (r_bs[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_bs    <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_raw   <= '0;
            r_done  <= 1'b0;
            r_aerr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_aerr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        // Freeze the whole request so later input wiggles are ignored.
                        r_idx   <= addr[ADDR_WIDTH+1:2];
                        r_bs    <= byte_slct;
                        r_wdata <= wdata;
                        r_rd    <= ReadMem;
                        r_wr    <= WriteMem;
                        r_err   <= w_err;
                        r_cnt   <= LP_WAIT;
                        r_state <= (LP_WAIT == 4'd0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_rd) begin
                        // A read-type error returns zero rather than aliased array data.
                        r_raw <= r_err ? 32'd0 : r_mem[r_idx];
                    end
                    r_done  <= 1'b1;
                    r_aerr  <= r_err;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    // Request inputs here are still the completed request; ignore them.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_stall    = ((r_state == ST_IDLE) && w_req) ||
                          (r_state == ST_WAIT) || (r_state == ST_ACCESS);
    assign mem_done     = r_done;
    assign addr_err     = r_aerr;
    assign raw_mem_data = r_raw;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Instance with WAIT_CYCLES=2
    logic        rd2 = 1'b0, wr2 = 1'b0;
    logic [31:0] a2 = '0, wd2 = '0;
    logic [3:0]  bs2 = '0;
    logic [31:0] raw2;
    logic        stall2, done2, err2;

    // Instance with WAIT_CYCLES=0
    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] a0 = '0, wd0 = '0;
    logic [3:0]  bs0 = '0;
    logic [31:0] raw0;
    logic        stall0, done0, err0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .ReadMem(rd2), .WriteMem(wr2), .addr(a2),
        .byte_slct(bs2), .wdata(wd2), .raw_mem_data(raw2),
        .mem_stall(stall2), .mem_done(done2), .addr_err(err2)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .ReadMem(rd0), .WriteMem(wr0), .addr(a0),
        .byte_slct(bs0), .wdata(wd0), .raw_mem_data(raw0),
        .mem_stall(stall0), .mem_done(done0), .addr_err(err0)
    );

    task automatic drive(input bit use0, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [3:0] bs, input logic [31:0] wd);
        if (use0) begin
            rd0 = rd; wr0 = wr; a0 = a; bs0 = bs; wd0 = wd;
        end else begin
            rd2 = rd; wr2 = wr; a2 = a; bs2 = bs; wd2 = wd;
        end
    endtask

    // Presents a request, counts stall cycles until the DONE cycle, then releases inputs.
    task automatic run_req(input bit use0, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [3:0] bs, input logic [31:0] wd,
                           output int ncyc, output logic done_s, output logic err_s,
                           output logic early);
        @(negedge clk);
        drive(use0, rd, wr, a, bs, wd);
        #1;
        ncyc  = 0;
        early = 1'b0;
        while ((use0 ? stall0 : stall2) === 1'b1 && ncyc < 40) begin
            ncyc++;
            if ((use0 ? done0 : done2) !== 1'b0) early = 1'b1;
            @(negedge clk);
            #1;
        end
        done_s = use0 ? done0 : done2;
        err_s  = use0 ? err0 : err2;
        drive(use0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (raw2 !== 32'd0)  begin failures++; $display("FAIL reset_raw got=%h exp=0", raw2); end
        checks++; if (stall2 !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall2); end
        checks++; if (done2 !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done2); end
        checks++; if (err2 !== 1'b0)   begin failures++; $display("FAIL reset_err got=%b exp=0", err2); end
        checks++; if (raw0 !== 32'd0)  begin failures++; $display("FAIL reset_raw0 got=%h exp=0", raw0); end
        rst = 1'b0;
    endtask

    task automatic test_write_basic;
        int n; logic d, e, early;
        run_req(1'b0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, n, d, e, early);
        checks++; if (n !== 4)        begin failures++; $display("FAIL wr_stall_cycles got=%0d exp=4", n); end
        checks++; if (d !== 1'b1)     begin failures++; $display("FAIL wr_done got=%b exp=1", d); end
        checks++; if (e !== 1'b0)     begin failures++; $display("FAIL wr_err got=%b exp=0", e); end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL wr_early_done got=%b exp=0", early); end
        @(negedge clk); #1;
        checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL wr_done_pulse got=%b exp=0", done2); end
    endtask

    task automatic test_read_basic;
        int n; logic d, e, early;
        run_req(1'b0, 1'b1, 1'b0, 32'h10, 4'h1, 32'h0, n, d, e, early);
        checks++; if (n !== 4)              begin failures++; $display("FAIL rd_stall_cycles got=%0d exp=4", n); end
        checks++; if (d !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL rd_done_err got=%b%b exp=10", d, e); end
        checks++; if (raw2 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", raw2); end
        repeat (3) @(negedge clk); #1;
        checks++; if (raw2 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_hold_idle got=%h exp=deadbeef", raw2); end
        run_req(1'b0, 1'b0, 1'b1, 32'h14, 4'hF, 32'h55555555, n, d, e, early);
        checks++; if (raw2 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_hold_write got=%h exp=deadbeef", raw2); end
    endtask

    task automatic test_partial_store;
        int n; logic d, e, early;
        run_req(1'b0, 1'b0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, n, d, e, early);
        run_req(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, n, d, e, early);
        checks++; if (raw2 !== 32'hDEADAAEF) begin failures++; $display("FAIL partial_merge got=%h exp=deadaaef", raw2); end
        run_req(1'b0, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0, n, d, e, early);
        checks++; if (raw2 !== 32'h55555555) begin failures++; $display("FAIL partial_other_word got=%h exp=55555555", raw2); end
    endtask

    task automatic test_addr_err;
        int n; logic d, e, early;
        run_req(1'b0, 1'b1, 1'b0, 32'h00001000, 4'hF, 32'h0, n, d, e, early);
        checks++; if (d !== 1'b1 || e !== 1'b1) begin failures++; $display("FAIL oor_rd_pulses got=%b%b exp=11", d, e); end
        checks++; if (raw2 !== 32'd0) begin failures++; $display("FAIL oor_rd_data got=%h exp=0", raw2); end
        // 0x1010 aliases word 4 (= 0x10) if the upper bits were dropped.
        run_req(1'b0, 1'b0, 1'b1, 32'h00001010, 4'hF, 32'h00000000, n, d, e, early);
        checks++; if (d !== 1'b1 || e !== 1'b1) begin failures++; $display("FAIL oor_wr_pulses got=%b%b exp=11", d, e); end
        run_req(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, n, d, e, early);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL oor_followup_err got=%b exp=0", e); end
        checks++; if (raw2 !== 32'hDEADAAEF) begin failures++; $display("FAIL oor_wr_unchanged got=%h exp=deadaaef", raw2); end
    endtask

    task automatic test_both_ops;
        int n; logic d, e, early;
        run_req(1'b0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h11111111, n, d, e, early);
        checks++; if (n !== 4) begin failures++; $display("FAIL both_stall_cycles got=%0d exp=4", n); end
        checks++; if (d !== 1'b1 || e !== 1'b1) begin failures++; $display("FAIL both_pulses got=%b%b exp=11", d, e); end
        run_req(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, n, d, e, early);
        checks++; if (raw2 !== 32'hDEADAAEF) begin failures++; $display("FAIL both_no_write got=%h exp=deadaaef", raw2); end
    endtask

    task automatic test_byte_slct_zero;
        int n; logic d, e, early;
        run_req(1'b0, 1'b0, 1'b1, 32'h10, 4'h0, 32'h00000000, n, d, e, early);
        checks++; if (d !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL bs0_pulses got=%b%b exp=10", d, e); end
        run_req(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, n, d, e, early);
        checks++; if (raw2 !== 32'hDEADAAEF) begin failures++; $display("FAIL bs0_unchanged got=%h exp=deadaaef", raw2); end
    endtask

    task automatic test_reset_mid;
        int n; logic d, e, early;
        run_req(1'b0, 1'b0, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, n, d, e, early);
        run_req(1'b0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, n, d, e, early);
        checks++; if (raw2 !== 32'hCAFEF00D) begin failures++; $display("FAIL rstmid_prior got=%h exp=cafef00d", raw2); end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h20, 4'hF, 32'h12345678);
        @(negedge clk); #1;
        checks++; if (stall2 !== 1'b1) begin failures++; $display("FAIL rstmid_in_wait got=%b exp=1", stall2); end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        checks++; if (stall2 !== 1'b0 || done2 !== 1'b0 || err2 !== 1'b0)
            begin failures++; $display("FAIL rstmid_ctrl got=%b%b%b exp=000", stall2, done2, err2); end
        checks++; if (raw2 !== 32'd0) begin failures++; $display("FAIL rstmid_raw got=%h exp=0", raw2); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_req(1'b0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, n, d, e, early);
        checks++; if (raw2 !== 32'hCAFEF00D) begin failures++; $display("FAIL rstmid_abandoned got=%h exp=cafef00d", raw2); end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h30, 4'hF, 32'h01020304);
        #1;
        n = 0;
        while (stall2 === 1'b1 && n < 40) begin n++; @(negedge clk); #1; end
        checks++; if (done2 !== 1'b1) begin failures++; $display("FAIL b2b_first_done got=%b exp=1", done2); end
        // Next request is presented during DONE; it must not stall until IDLE.
        drive(1'b0, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
        #1;
        checks++; if (stall2 !== 1'b0) begin failures++; $display("FAIL b2b_done_stall got=%b exp=0", stall2); end
        @(negedge clk); #1;
        checks++; if (stall2 !== 1'b1 || done2 !== 1'b0)
            begin failures++; $display("FAIL b2b_accept got=%b%b exp=10", stall2, done2); end
        n = 0;
        while (stall2 === 1'b1 && n < 40) begin n++; @(negedge clk); #1; end
        checks++; if (n !== 4 || done2 !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0d,%b exp=4,1", n, done2); end
        checks++; if (raw2 !== 32'h01020304) begin failures++; $display("FAIL b2b_data got=%h exp=01020304", raw2); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_wait0;
        int n; logic d, e, early;
        run_req(1'b1, 1'b0, 1'b1, 32'h8, 4'hF, 32'h0BADF00D, n, d, e, early);
        checks++; if (n !== 2 || d !== 1'b1) begin failures++; $display("FAIL w0_write got=%0d,%b exp=2,1", n, d); end
        run_req(1'b1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, n, d, e, early);
        checks++; if (n !== 2 || d !== 1'b1 || e !== 1'b0 || early !== 1'b0)
            begin failures++; $display("FAIL w0_read got=%0d,%b%b%b exp=2,100", n, d, e, early); end
        checks++; if (raw0 !== 32'h0BADF00D) begin failures++; $display("FAIL w0_data got=%h exp=0badf00d", raw0); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_partial_store();
        test_addr_err();
        test_both_ops();
        test_byte_slct_zero();
        test_reset_mid();
        test_back_to_back();
        test_wait0();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
